// File: rtl/interval_timer.sv
// Interval timer: fetches a seconds value from the time-parameter store, optionally
// doubles it, counts it down on a 1 Hz enable and pulses expired at the end.
module interval_timer #(
  parameter int VALUE_W = 4,
  parameter int SEL_W   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_timer,
  input  logic [SEL_W-1:0]   interval_sel,
  input  logic               double_interval,
  input  logic               one_hz_enable,
  output logic [SEL_W-1:0]   param_select,
  input  logic [VALUE_W-1:0] param_value,
  output logic [VALUE_W:0]   remaining,
  output logic               busy,
  output logic               expired,
  output logic [1:0]         state_dbg
);

  // Handshake: start_timer is a valid-only request with no ready; it is accepted
  // in every state and a start seen in FETCH/COUNT/DONE restarts the interval.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [SEL_W-1:0] SEL_YEL  = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_RSVD = SEL_W'(3);
  localparam logic [VALUE_W:0] REM_ONE  = (VALUE_W+1)'(1);
  localparam logic [VALUE_W:0] REM_ZERO = '0;

  state_t             state, state_n;
  logic [SEL_W-1:0]   sel_n;
  logic               dbl, dbl_n;
  logic [VALUE_W:0]   rem_n;
  logic [SEL_W-1:0]   sel_coerced;
  logic [VALUE_W:0]   load_value;

  // The reserved selector code maps onto the yellow interval.
  assign sel_coerced = (interval_sel == SEL_RSVD) ? SEL_YEL : interval_sel;
  assign load_value  = dbl ? {param_value, 1'b0} : {1'b0, param_value};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      param_select <= '0;
      dbl          <= 1'b0;
      remaining    <= '0;
    end else begin
      state        <= state_n;
      param_select <= sel_n;
      dbl          <= dbl_n;
      remaining    <= rem_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = param_select;
    dbl_n   = dbl;
    rem_n   = remaining;
    if (start_timer) begin
      // A start in any state wins over counting, loading or expiring.
      sel_n   = sel_coerced;
      dbl_n   = double_interval;
      state_n = FETCH;
    end else begin
      case (state)
        IDLE: state_n = IDLE;
        FETCH: begin
          rem_n   = load_value;
          state_n = (load_value == REM_ZERO) ? DONE : COUNT;
        end
        COUNT: begin
          if (one_hz_enable) begin
            rem_n = remaining - REM_ONE;
            if (remaining == REM_ONE) state_n = DONE;
          end
        end
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy      = (state == FETCH) || (state == COUNT);
  assign expired   = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer: directed scenarios plus random traffic, all checked
// cycle by cycle against an abstract countdown model of the timer.
module tb_interval_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_timer;
  logic [1:0] interval_sel;
  logic       double_interval;
  logic       one_hz_enable;
  logic [1:0] param_select;
  logic [3:0] param_value;
  logic [4:0] remaining;
  logic       busy;
  logic       expired;
  logic [1:0] state_dbg;

  logic [3:0] store [4];
  assign param_value = store[param_select];

  interval_timer #(.VALUE_W(4), .SEL_W(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_timer     (start_timer),
    .interval_sel    (interval_sel),
    .double_interval (double_interval),
    .one_hz_enable   (one_hz_enable),
    .param_select    (param_select),
    .param_value     (param_value),
    .remaining       (remaining),
    .busy            (busy),
    .expired         (expired),
    .state_dbg       (state_dbg)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];

  // Abstract model: a pending fetch, a running countdown, and a one-cycle expiry flag.
  logic [1:0] m_sel;
  bit         m_dbl, m_fetch, m_run, m_expire;
  int         m_secs;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel = 2'd0; m_dbl = 0; m_fetch = 0; m_run = 0; m_expire = 0; m_secs = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit st, input logic [1:0] sel, input bit dbl, input bit en);
    bit exp_now = 0;
    if (st) begin
      m_sel = (sel == 2'd3) ? 2'd2 : sel;
      m_dbl = dbl; m_fetch = 1; m_run = 0;
    end else if (m_fetch) begin
      m_fetch = 0;
      m_secs = int'(store[m_sel]) * (m_dbl ? 2 : 1);
      if (m_secs == 0) exp_now = 1;
      else m_run = 1;
    end else if (m_run && en) begin
      m_secs = m_secs - 1;
      if (m_secs == 0) begin
        m_run = 0; exp_now = 1;
      end
    end
    m_expire = exp_now;
    exp_q.push_back({m_sel, 5'(m_secs), m_fetch | m_run, m_expire});
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare at the negedge.
  task automatic tick(input bit st, input logic [1:0] sel, input bit dbl, input bit en);
    logic [8:0] e;
    start_timer = st; interval_sel = sel; double_interval = dbl; one_hz_enable = en;
    @(posedge clk);
    if (!reset) model_reset();
    else model_step(st, sel, dbl, en);
    @(negedge clk);
    if (exp_q.size() == 0) e = 9'd0;
    else e = exp_q.pop_front();
    check("param_select", 16'(param_select), 16'(e[8:7]));
    check("remaining", 16'(remaining), 16'(e[6:2]));
    check("busy", 16'(busy), 16'(e[1]));
    check("expired", 16'(expired), 16'(e[0]));
    start_timer = 0; one_hz_enable = 0; double_interval = 0;
  endtask

  task automatic enables(input int n);
    for (int i = 0; i < n; i++) tick(0, 2'd0, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    store[0] = 4'd6; store[1] = 4'd3; store[2] = 4'd2; store[3] = 4'd0;
    reset = 0; start_timer = 0; interval_sel = 0; double_interval = 0; one_hz_enable = 0;
    model_reset();

    // 1: reset then a YEL interval
    repeat (3) tick(0, 2'd0, 0, 0);
    check("rst_rem", 16'(remaining), 16'd0);
    check("rst_sel", 16'(param_select), 16'd0);
    reset = 1;
    tick(1, 2'd2, 0, 0);
    check("s1_sel", 16'(param_select), 16'd2);
    check("s1_busy_fetch", 16'(busy), 16'd1);
    tick(0, 2'd0, 0, 0);
    check("s1_rem", 16'(remaining), 16'd2);
    enables(2);
    check("s1_expired", 16'(expired), 16'd1);
    check("s1_busy_done", 16'(busy), 16'd0);
    tick(0, 2'd0, 0, 0);
    check("s1_expired_once", 16'(expired), 16'd0);

    // 2: doubled BASE, then reserved selector
    tick(1, 2'd0, 1, 0);
    tick(0, 2'd0, 0, 0);
    check("s2_rem_dbl", 16'(remaining), 16'd12);
    enables(12);
    check("s2_expired", 16'(expired), 16'd1);
    tick(0, 2'd0, 0, 0);
    tick(1, 2'd3, 0, 0);
    check("s2_sel_coerce", 16'(param_select), 16'd2);
    tick(0, 2'd0, 0, 0);
    check("s2_rem_yel", 16'(remaining), 16'd2);
    enables(2);
    tick(0, 2'd0, 0, 0);

    // 3: zero-length EXT
    store[1] = 4'd0;
    tick(1, 2'd1, 0, 0);
    check("s3_busy_fetch", 16'(busy), 16'd1);
    tick(0, 2'd0, 0, 0);
    check("s3_expired", 16'(expired), 16'd1);
    check("s3_busy", 16'(busy), 16'd0);
    tick(0, 2'd0, 0, 0);
    store[1] = 4'd3;

    // 4: restarts colliding with enables
    tick(1, 2'd0, 0, 0);
    tick(0, 2'd0, 0, 0);
    enables(2);
    check("s4_rem4", 16'(remaining), 16'd4);
    tick(1, 2'd1, 0, 1);
    check("s4_no_dec", 16'(remaining), 16'd4);
    tick(0, 2'd0, 0, 0);
    check("s4_rem3", 16'(remaining), 16'd3);
    enables(2);
    tick(1, 2'd1, 0, 1);
    check("s4_no_expired", 16'(expired), 16'd0);
    tick(0, 2'd0, 0, 0);
    check("s4_reload", 16'(remaining), 16'd3);
    enables(3);
    tick(0, 2'd0, 0, 0);

    // 5: reprogram mid-count, start held in DONE
    tick(1, 2'd0, 0, 0);
    tick(0, 2'd0, 0, 0);
    enables(1);
    check("s5_rem5", 16'(remaining), 16'd5);
    store[0] = 4'd10;
    enables(5);
    check("s5_expired", 16'(expired), 16'd1);
    tick(0, 2'd0, 0, 0);
    tick(1, 2'd0, 0, 0);
    tick(0, 2'd0, 0, 0);
    check("s5_rem10", 16'(remaining), 16'd10);
    enables(10);
    check("s5_expired2", 16'(expired), 16'd1);
    tick(1, 2'd0, 0, 0);
    check("s5_busy_after_done", 16'(busy), 16'd1);
    tick(0, 2'd0, 0, 0);
    enables(7);
    check("s5_rem3", 16'(remaining), 16'd3);

    // 6: asynchronous reset mid-count
    #5 reset = 0;
    #1;
    check("s6_rem_async", 16'(remaining), 16'd0);
    check("s6_busy_async", 16'(busy), 16'd0);
    check("s6_expired_async", 16'(expired), 16'd0);
    model_reset();
    @(negedge clk);
    tick(0, 2'd0, 0, 0);
    reset = 1;
    store[0] = 4'd6;
    tick(1, 2'd2, 0, 0);
    check("s6_sel", 16'(param_select), 16'd2);
    tick(0, 2'd0, 0, 0);
    check("s6_rem", 16'(remaining), 16'd2);
    enables(2);
    check("s6_expired", 16'(expired), 16'd1);
    tick(0, 2'd0, 0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) store[$urandom_range(0, 2)] = 4'($urandom_range(0, 15));
      tick($urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)),
           bit'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Consumer side of the time-parameter store. Selects one of t_BASE / t_EXT / t_YEL through the store's selector and captures the returned 4-bit seconds value.
- Counts the interval down on a 1 Hz enable and pulses expired when it ends.
- Sits between the traffic-light FSM, which issues start requests, and the parameter store, which answers selector with t_value_output combinationally in the same cycle.

Parameters:
- VALUE_W, 4, width of a stored time value in seconds.
- SEL_W, 2, width of the parameter selector (00 BASE, 01 EXT, 10 YEL, 11 reserved).

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-low reset.
- start_timer  in  1  one-cycle request to start, or restart, an interval.
- interval_sel  in  SEL_W  interval to run; sampled with start_timer.
- double_interval  in  1  when 1, the loaded value is doubled; sampled with start_timer.
- one_hz_enable  in  1  one-cycle pulse once per second.
- param_select  out  SEL_W  registered selector driven to the parameter store.
- param_value  in  VALUE_W  value returned by the store for param_select.
- remaining  out  VALUE_W+1  seconds left in the current interval.
- busy  out  1  high while in FETCH or COUNT.
- expired  out  1  one-cycle pulse at end of interval.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, param_select=00, remaining=0, busy=0, expired=0, dbl latch=0. Releasing reset takes effect at the next clk edge.
- States: IDLE, FETCH, COUNT, DONE. All outputs are registered or decoded from the registered state. expired=1 only in DONE. busy=1 only in FETCH and COUNT.
- IDLE: start_timer=1 → param_select<=interval_sel (11 is coerced to 10, YEL); dbl<=double_interval; state<=FETCH. Otherwise hold; remaining holds its last value.
- FETCH, exactly 1 cycle:
  - load value V = param_value zero-extended to VALUE_W+1, shifted left 1 if dbl (max 30 at VALUE_W=4, no overflow).
  - remaining<=V.
  - V==0 → state<=DONE. Otherwise state<=COUNT.
  - one_hz_enable in FETCH is ignored, so the first second may be short by up to 1 s. This is accepted.
- COUNT:
  - one_hz_enable=1 → remaining<=remaining-1.
  - If remaining==1 at that edge → remaining<=0 and state<=DONE.
  - No enable → hold.
- DONE, 1 cycle: expired=1. Next state is IDLE, or FETCH if start_timer=1 in this cycle (param_select/dbl latched as in IDLE). In the start-in-DONE case, expired still pulses.
- Restart: start_timer=1 in FETCH or COUNT → relatch param_select/dbl, state<=FETCH. The abandoned interval produces no expired.
  - Simultaneous start_timer and one_hz_enable in COUNT: start wins, no decrement.
  - Simultaneous start_timer with the terminal enable (remaining==1): start wins, no expired.
- Latency: start at edge N → FETCH during cycle N+1 → remaining valid at N+2. expired is high the cycle after the enable edge that reaches 0. Total interval = V enable pulses after FETCH.
- Store reprogramming while COUNT runs does not affect the running interval; the value is captured only in FETCH. param_select stays stable outside start/restart.
- Reset asserted mid-interval: immediate return to reset values, no expired pulse.

Test Plan:
1. Bench store model BASE=6, EXT=3, YEL=2. Reset low 3 cycles → all outputs 0, param_select=00. Start sel=10 → param_select=10 at N+1, remaining=2 at N+2, busy=1. After the 2nd enable pulse: remaining=0, expired=1 for exactly 1 cycle, busy=0.
2. Start sel=00 with double_interval=1 → remaining=12. Twelve enables → single expired. Start sel=11 → param_select=10, remaining=2.
3. Store returns 0 for EXT; start sel=01 → FETCH, then DONE with expired on the cycle after FETCH, never COUNT.
4. During a BASE interval at remaining=4: assert start sel=01 together with one_hz_enable → no decrement, remaining=3 two cycles later, no expired for the aborted interval. Repeat the start with the terminal enable at remaining=1 → no expired.
5. Change the store BASE to 10 (reprogram) mid-count at remaining=5 → count continues 5→0. Next BASE start loads 10. Start_timer held high in DONE → expired pulses and FETCH follows.
6. Drop reset at remaining=3 in COUNT, between clk edges → outputs clear asynchronously, no expired. After release, state is IDLE and start behaves as in scenario 1.
